// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - Bit-serial add/subtract sequencer driving one shared 1-bit full-adder slice.
// Operands stream LSB-first through the external slice; carry is chained through r_carry.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  output logic             fa_sel,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_cout;
  logic             r_ovf;
  logic             w_run;
  logic             w_last;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh_a   <= op_a;
            r_sh_b   <= op_b;
            r_sub    <= sub;
            // Subtract seeds carry=1: the +1 of the two's-complement negation.
            r_carry  <= sub;
            r_cnt    <= '0;
            r_result <= '0;
          end
        end
        S_RUN: begin
          r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
          r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
          r_result <= {fa_sum, r_result[WIDTH-1:1]};
          r_carry  <= fa_cout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= fa_cout;
            // Signed overflow: carry into the MSB differs from carry out of it.
            r_ovf  <= r_carry ^ fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fa_a   = w_run & r_sh_a[0];
  assign fa_b   = w_run & r_sh_b[0];
  assign fa_cin = w_run & r_carry;
  assign fa_sel = r_sub;

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial sequencer for the 1-bit selectable full-adder slice (a, b, cin, selector → sum, cout). It accepts a WIDTH-bit add or subtract request, feeds the operands to the slice LSB-first one bit per clock, and chains the carry through a register. It then returns the WIDTH-bit result with carry-out and signed overflow. It sits between a requesting datapath and one shared slice instance, so a single adder cell can serve multi-bit arithmetic.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op_a  in  WIDTH  operand A, captured on accepted start
- op_b  in  WIDTH  operand B, captured on accepted start
- sub  in  1  0 = A+B, 1 = A−B; captured on accepted start
- fa_a  out  1  slice input a
- fa_b  out  1  slice input b (raw operand bit; slice inverts it when selector=1)
- fa_cin  out  1  slice carry-in
- fa_sel  out  1  slice selector
- fa_sum  in  1  slice sum
- fa_cout  in  1  slice carry-out
- busy  out  1  high while in RUN or DONE
- done  out  1  one-cycle pulse; result/cout/ovf are valid
- result  out  WIDTH  A±B mod 2^WIDTH
- cout  out  1  final carry-out (sub: 1 = no borrow)
- ovf  out  1  two's-complement overflow

## Operation
- Slice contract: b' = b XOR selector; sum = a^b'^cin; cout = majority(a, b', cin).
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - load sh_a←op_a, sh_b←op_b, sub_q←sub, carry←sub (the +1 of two's complement), cnt←0, clear the result shift register.
  - Go to RUN.
- IDLE, start=0: hold all registers.
- RUN: fa_a=sh_a[0], fa_b=sh_b[0], fa_cin=carry, fa_sel=sub_q (all combinational from registers). Each clock:
  - shift sh_a and sh_b right;
  - shift fa_sum into the result MSB (result shifts right);
  - carry←fa_cout; cnt←cnt+1.
- RUN, cnt=WIDTH−1: on that edge, latch cout←fa_cout and ovf←carry XOR fa_cout (carry into MSB vs carry out). Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. result/cout/ovf hold until the next accepted start.
- start while busy (RUN or DONE) is ignored and not queued.
- Outside RUN: fa_a=fa_b=fa_cin=0 and fa_sel=sub_q.
- cnt width = clog2(WIDTH). No other arithmetic beyond the slice.

## Timing
- Reset (async assert, sync release):
  - state=IDLE;
  - result, cout, ovf, done, busy, cnt, carry, sub_q, and all fa_* outputs = 0.
- Start accepted at edge 0.
- Bit i is presented during cycle i+1 and consumed at edge i+1, for i=0..WIDTH−1.
- done is high in the cycle after edge WIDTH, i.e. latency WIDTH+1 edges from start to done.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is sampled in the cycle after done.
- busy rises the cycle after the accepting edge and falls together with done.
- Reset mid-RUN/DONE: immediate abort. No done pulse; outputs cleared. Slice inputs go to 0 asynchronously.
- Operand inputs may change freely after the accepting edge.

## Test plan
- WIDTH=8, op_a=0x3C, op_b=0x05, sub=0 → done at edge 9; result=0x41, cout=0, ovf=0; busy high for cycles 1–9.
- Add overflow: op_a=0x7F, op_b=0x01, sub=0 → result=0x80, cout=0, ovf=1. Then 0xFF+0x01 → result=0x00, cout=1, ovf=0.
- Subtract: op_a=0x05, op_b=0x07, sub=1 → result=0xFE, cout=0 (borrow), ovf=0. Then 0x80−0x01 → result=0x7F, cout=1, ovf=1.
- Ignored request: during RUN, pulse start with op_a=0xAA, op_b=0x11 → result unchanged from the first request, and only one done pulse.
- Reset abort: assert rst_n=0 at bit 4 of 0x3C+0x05 → all outputs 0 immediately, no done. After release, start 0x10+0x20 → result=0x30 at edge 9.
- Back-to-back: start asserted continuously → accepts every WIDTH+2 cycles. Checked against a bench slice model and a reference A±B mod 256 for 200 random operand/sub triples.
